// File: rtl/prim_packer_pkg.sv
// Shared helpers for the FIFO word packer: fill-counter sizing and mask generation.
package prim_packer_pkg;

  // Upper bound on words per beat that the mask helper can describe.
  localparam int unsigned MaxRatio = 64;

  // Width of a counter able to hold 0..ratio.
  function automatic int unsigned fill_width(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

  // Thermometer mask: bit k set for every word index below fill (and below ratio).
  function automatic logic [MaxRatio-1:0] fill_to_mask(input int unsigned fill,
                                                       input int unsigned ratio);
    logic [MaxRatio-1:0] mask;
    mask = '0;
    for (int unsigned k = 0; k < MaxRatio; k++) begin
      mask[k] = (k < fill) && (k < ratio);
    end
    return mask;
  endfunction

endpackage

// File: rtl/prim_fifo_word_packer.sv
// Packs Ratio consecutive Width-bit FIFO words into one wide beat with a per-word valid mask.
// A flush request emits the partially filled accumulator as a masked beat.
module prim_fifo_word_packer
  import prim_packer_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned Ratio = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clr_i,
  input  logic                            wvalid_i,
  output logic                            wready_o,
  input  logic [Width-1:0]                wdata_i,
  input  logic                            flush_i,
  output logic                            rvalid_o,
  input  logic                            rready_i,
  output logic [Width*Ratio-1:0]          rdata_o,
  output logic [Ratio-1:0]                rmask_o,
  output logic [fill_width(Ratio)-1:0]    fill_o
);

  localparam int unsigned FillW = fill_width(Ratio);
  localparam logic [FillW-1:0] LastFill = FillW'(Ratio - 1);

  logic [Ratio-1:0][Width-1:0] acc_q, acc_d;
  logic [FillW-1:0]            fill_q, fill_d;
  logic                        flush_q, flush_d;
  logic [Width*Ratio-1:0]      rdata_q, rdata_d;
  logic [Ratio-1:0]            rmask_q, rmask_d;
  logic                        rvalid_q, rvalid_d;
  logic                        out_free;
  logic                        accept;

  // Output register may reload in the same cycle it is popped.
  assign out_free = !rvalid_q || rready_i;
  assign wready_o = !flush_q && ((fill_q != LastFill) || out_free);
  assign accept   = wvalid_i && wready_o;

  // Next-state: flush drain takes precedence; otherwise accumulate or complete a beat.
  always_comb begin
    acc_d    = acc_q;
    fill_d   = fill_q;
    flush_d  = flush_q;
    rdata_d  = rdata_q;
    rmask_d  = rmask_q;
    rvalid_d = rvalid_q && !rready_i;

    if (flush_q) begin
      // wready_o is low here, so no word can arrive while draining.
      if (out_free) begin
        flush_d = 1'b0;
        if (fill_q != '0) begin
          // Words at and above fill_q are already zero since acc clears on every emit.
          rdata_d  = acc_q;
          rmask_d  = Ratio'(fill_to_mask(32'(fill_q), Ratio));
          rvalid_d = 1'b1;
          acc_d    = '0;
          fill_d   = '0;
        end
      end
    end else begin
      flush_d = flush_i;
      if (accept) begin
        if (fill_q == LastFill) begin
          rdata_d  = {wdata_i, acc_q[Ratio-2:0]};
          rmask_d  = '1;
          rvalid_d = 1'b1;
          acc_d    = '0;
          fill_d   = '0;
        end else begin
          for (int unsigned k = 0; k < Ratio; k++) begin
            if (fill_q == FillW'(k)) begin
              acc_d[k] = wdata_i;
            end
          end
          fill_d = fill_q + FillW'(1);
        end
      end
    end
  end

  // State registers with synchronous reset/clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_q    <= '0;
      fill_q   <= '0;
      flush_q  <= 1'b0;
      rdata_q  <= '0;
      rmask_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      fill_q   <= fill_d;
      flush_q  <= flush_d;
      rdata_q  <= rdata_d;
      rmask_q  <= rmask_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rmask_o  = rmask_q;
  assign fill_o   = fill_q;

endmodule

// File: tb/tb_prim_fifo_word_packer.sv
// Directed and randomized checks for prim_fifo_word_packer (Width=8, Ratio=4).
module tb_prim_fifo_word_packer;

  localparam int unsigned Width = 8;
  localparam int unsigned Ratio = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [7:0]  wdata = '0;
  logic        flush = 1'b0;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] rdata;
  logic [3:0]  rmask;
  logic [2:0]  fill;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prim_fifo_word_packer #(
    .Width (Width),
    .Ratio (Ratio)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (clr),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .wdata_i  (wdata),
    .flush_i  (flush),
    .rvalid_o (rvalid),
    .rready_i (rready),
    .rdata_o  (rdata),
    .rmask_o  (rmask),
    .fill_o   (fill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and return 1 time unit after the edge that accepts it.
  task automatic push(input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    wvalid = 1'b1;
    wdata  = w;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("push_timeout", 32'(ok), 32'd1);
    tick();
    wvalid = 1'b0;
  endtask

  // Random-phase scoreboard state.
  logic [31:0] exp_q[$];
  logic [31:0] cur_beat;
  int          cur_cnt;
  int          n_words;
  logic [31:0] prev_rdata;
  logic [3:0]  prev_rmask;
  bit          prev_stall;
  bit          exp_wready;
  bit          acc_now;
  logic [31:0] exp_beat;

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rmask", 32'(rmask), 32'h0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_wready", 32'(wready), 32'd1);
    tick();

    // Full beat, streaming
    rready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    chk("t1_fill3", 32'(fill), 32'd3);
    chk("t1_novalid", 32'(rvalid), 32'd0);
    push(8'h44);
    chk("t1_rvalid", 32'(rvalid), 32'd1);
    chk("t1_rdata", rdata, 32'h44332211);
    chk("t1_rmask", 32'(rmask), 32'hf);
    chk("t1_fill0", 32'(fill), 32'd0);
    tick();
    chk("t1_rvalid_drop", 32'(rvalid), 32'd0);
    chk("t1_rdata_hold", rdata, 32'h44332211);

    // Backpressure with a pending full beat
    rready = 1'b0;
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    push(8'hA1); push(8'hA2); push(8'hA3);
    wvalid = 1'b1;
    wdata  = 8'hA4;
    @(negedge clk);
    chk("t2_wready_blocked", 32'(wready), 32'd0);
    chk("t2_rdata_held", rdata, 32'h40302010);
    chk("t2_rvalid_held", 32'(rvalid), 32'd1);
    rready = 1'b1;
    #1;
    chk("t2_wready_comb", 32'(wready), 32'd1);
    tick();
    wvalid = 1'b0;
    chk("t2_rvalid", 32'(rvalid), 32'd1);
    chk("t2_rdata", rdata, 32'hA4A3A2A1);
    chk("t2_rmask", 32'(rmask), 32'hf);
    tick();
    chk("t2_drain", 32'(rvalid), 32'd0);

    // Flush of a partial beat
    push(8'h55); push(8'h66);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t3_wready_flush", 32'(wready), 32'd0);
    chk("t3_fill2", 32'(fill), 32'd2);
    tick();
    chk("t3_rvalid", 32'(rvalid), 32'd1);
    chk("t3_rdata", rdata, 32'h00006655);
    chk("t3_rmask", 32'(rmask), 32'h3);
    chk("t3_fill0", 32'(fill), 32'd0);
    chk("t3_wready_back", 32'(wready), 32'd1);
    tick();

    // Word in the flush cycle is included
    wvalid = 1'b1;
    wdata  = 8'h77;
    flush  = 1'b1;
    tick();
    wvalid = 1'b0;
    flush  = 1'b0;
    chk("t4_fill1", 32'(fill), 32'd1);
    tick();
    chk("t4_rvalid", 32'(rvalid), 32'd1);
    chk("t4_rdata", rdata, 32'h00000077);
    chk("t4_rmask", 32'(rmask), 32'h1);
    tick();
    // Flush with nothing held emits no beat
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_empty_wready", 32'(wready), 32'd0);
    tick();
    chk("t4_empty_nobeat", 32'(rvalid), 32'd0);
    tick();
    chk("t4_empty_nobeat2", 32'(rvalid), 32'd0);
    chk("t4_empty_wready2", 32'(wready), 32'd1);

    // Clear, then reset, discard accumulated words
    for (int pass = 0; pass < 2; pass++) begin
      push(8'h01); push(8'h02);
      if (pass == 0) clr = 1'b1; else rst = 1'b1;
      tick();
      clr = 1'b0;
      rst = 1'b0;
      chk("t5_fill_cleared", 32'(fill), 32'd0);
      chk("t5_rvalid_cleared", 32'(rvalid), 32'd0);
      push(8'h09); push(8'h0A); push(8'h0B); push(8'h0C);
      chk("t5_rvalid", 32'(rvalid), 32'd1);
      chk("t5_rdata", rdata, 32'h0C0B0A09);
      chk("t5_rmask", 32'(rmask), 32'hf);
      tick();
    end

    // Randomized stream against a word-queue scoreboard
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cur_cnt    = 0;
    n_words    = 0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 20000 && !(n_words >= 1000 && exp_q.size() == 0); cyc++) begin
      wvalid = (n_words < 1000) && ($urandom_range(99) < 60);
      wdata  = 8'($urandom);
      rready = ($urandom_range(99) < 70);
      @(negedge clk);
      exp_wready = (cur_cnt != 3) || (exp_q.size() == 0) || rready;
      chk("rnd_wready", 32'(wready), 32'(exp_wready));
      chk("rnd_rvalid", 32'(rvalid), 32'(exp_q.size() != 0));
      chk("rnd_fill", 32'(fill), 32'(cur_cnt));
      if (prev_stall) begin
        chk("rnd_stable_data", rdata, prev_rdata);
        chk("rnd_stable_mask", 32'(rmask), 32'(prev_rmask));
      end
      if (rvalid && rready && exp_q.size() != 0) begin
        exp_beat = exp_q.pop_front();
        chk("rnd_beat", rdata, exp_beat);
        chk("rnd_mask", 32'(rmask), 32'hf);
      end
      prev_stall = rvalid && !rready;
      prev_rdata = rdata;
      prev_rmask = rmask;
      acc_now = wvalid && exp_wready;
      if (acc_now) begin
        cur_beat[cur_cnt*8 +: 8] = wdata;
        cur_cnt++;
        n_words++;
        if (cur_cnt == 4) begin
          exp_q.push_back(cur_beat);
          cur_cnt = 0;
        end
      end
      tick();
    end
    chk("rnd_all_words", 32'(n_words), 32'd1000);
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
